// File: rtl/mnist_dlayer2_result_collector_pkg.sv
// Shared constants, collector state encoding and the fp32 total-order key
// used by the layer-2 result collector.
package mnist_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int DATA_W      = 32;
    localparam int IDX_W       = 4;

    typedef enum logic {
        COLLECT = 1'b0,
        DONE    = 1'b1
    } collect_state_e;

    // Maps an fp32 bit pattern to an unsigned key whose natural order is the
    // float order, with +0 above -0 and NaNs placed beyond the infinities.
    function automatic logic [DATA_W-1:0] fp32_order_key(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? ~x : (x | {1'b1, {(DATA_W-1){1'b0}}});
    endfunction

endpackage

// File: rtl/mnist_dlayer2_result_collector_if.sv
// Score stream in, argmax result out, between the layer-2 node unit and the
// result consumer.
interface mnist_dlayer2_result_collector_if;

    logic [mnist_pkg::DATA_W-1:0] c_in;
    logic                         c_valid;
    logic                         c_ready;
    logic                         result_valid;
    logic                         result_ready;
    logic [mnist_pkg::IDX_W-1:0]  class_idx;
    logic [mnist_pkg::DATA_W-1:0] class_score;
    logic [mnist_pkg::IDX_W-1:0]  frame_cnt;

    modport master (
        output c_in, c_valid, result_ready,
        input  c_ready, result_valid, class_idx, class_score, frame_cnt
    );

    modport slave (
        input  c_in, c_valid, result_ready,
        output c_ready, result_valid, class_idx, class_score, frame_cnt
    );

endinterface

// File: rtl/mnist_dlayer2_result_collector_cmp.sv
// Combinational fp32 "strictly greater" under the collector's total order.
module mnist_fp32_cmp_gt
    import mnist_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              gt
);

    assign gt = fp32_order_key(a) > fp32_order_key(b);

endmodule

// File: rtl/mnist_dlayer2_result_collector.sv
// Collects one fp32 score per class and presents the argmax class and score.
// Optional score readback buffer enabled by MNIST_SCORE_READBACK_EN.
module mnist_dlayer2_result_collector
    import mnist_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    mnist_dlayer2_result_collector_if.slave bus
`ifdef MNIST_SCORE_READBACK_EN
    ,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
`endif
);

    collect_state_e    state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] score_q, score_d;
    logic              rvalid_q, rvalid_d;
    logic              accept;
    logic              new_gt;

    mnist_fp32_cmp_gt u_cmp (
        .a  (bus.c_in),
        .b  (score_q),
        .gt (new_gt)
    );

    assign accept = bus.c_valid && (state_q == COLLECT) && !flush;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        score_d  = score_q;
        rvalid_d = rvalid_q;
        if (flush) begin
            state_d  = COLLECT;
            cnt_d    = '0;
            idx_d    = '0;
            score_d  = '0;
            rvalid_d = 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (accept) begin
                        // Strict compare keeps the earliest class on ties.
                        if ((cnt_q == '0) || new_gt) begin
                            idx_d   = cnt_q;
                            score_d = bus.c_in;
                        end
                        cnt_d = cnt_q + IDX_W'(1);
                        if (cnt_q == IDX_W'(NUM_CLASSES - 1)) begin
                            state_d  = DONE;
                            rvalid_d = 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.result_ready) begin
                        state_d  = COLLECT;
                        cnt_d    = '0;
                        idx_d    = '0;
                        score_d  = '0;
                        rvalid_d = 1'b0;
                    end
                end
                default: begin
                    state_d  = COLLECT;
                    rvalid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= COLLECT;
            cnt_q    <= '0;
            idx_q    <= '0;
            score_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            score_q  <= score_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.c_ready      = (state_q == COLLECT);
    assign bus.result_valid = rvalid_q;
    assign bus.class_idx    = idx_q;
    assign bus.class_score  = score_q;
    assign bus.frame_cnt    = cnt_q;

`ifdef MNIST_SCORE_READBACK_EN
    // Buffer survives flush; only reset or a new accepted beat changes it.
    logic [DATA_W-1:0] buf_q [NUM_CLASSES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CLASSES; i++) buf_q[i] <= '0;
        end else if (accept) begin
            buf_q[cnt_q] <= bus.c_in;
        end
    end

    assign rd_data = (rd_idx < IDX_W'(NUM_CLASSES)) ? buf_q[rd_idx] : '0;
`endif

endmodule

// File: tb/tb_mnist_dlayer2_result_collector.sv
// Directed bench for the layer-2 result collector: a frame-level reference
// model checked every cycle plus hand-computed expectations per frame.
module tb_mnist_dlayer2_result_collector;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    mnist_dlayer2_result_collector_if bus ();

    mnist_dlayer2_result_collector dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: stores the whole frame, picks argmax once it is complete.
    logic [31:0] m_buf [10];
    int          m_cnt;
    bit          m_done;

    function automatic logic [31:0] key(input logic [31:0] x);
        return x[31] ? ~x : (x | 32'h8000_0000);
    endfunction

    function automatic int m_argmax();
        int best = 0;
        for (int i = 1; i < 10; i++)
            if (key(m_buf[i]) > key(m_buf[best])) best = i;
        return best;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
        end else if (flush) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
        end else if (!m_done) begin
            if (bus.c_valid) begin
                m_buf[m_cnt] <= bus.c_in;
                m_cnt        <= m_cnt + 1;
                if (m_cnt == 9) m_done <= 1'b1;
            end
        end else if (bus.result_ready) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("c_ready", {31'd0, bus.c_ready}, {31'd0, !m_done});
            check("result_valid", {31'd0, bus.result_valid}, {31'd0, m_done});
            check("frame_cnt", {28'd0, bus.frame_cnt}, 32'(m_cnt));
            if (m_done) begin
                check("class_idx", {28'd0, bus.class_idx}, 32'(m_argmax()));
                check("class_score", bus.class_score, m_buf[m_argmax()]);
            end else if (m_cnt == 0) begin
                check("idx_cleared", {28'd0, bus.class_idx}, 32'd0);
                check("score_cleared", bus.class_score, 32'd0);
            end
        end
    end

    task automatic send_frame(input logic [31:0] s[10], input bit gap);
        for (int k = 0; k < 10; k++) begin
            bus.c_valid = 1'b1;
            bus.c_in    = s[k];
            @(posedge clk); #2;
            if (gap) begin
                bus.c_valid = 1'b0;
                bus.c_in    = 32'hDEAD_BEEF;
                @(posedge clk); #2;
            end
        end
        bus.c_valid = 1'b0;
    endtask

    task automatic expect_result(input string name, input int idx, input logic [31:0] score);
        check({name, "_valid"}, {31'd0, bus.result_valid}, 32'd1);
        check({name, "_idx"}, {28'd0, bus.class_idx}, 32'(idx));
        check({name, "_score"}, bus.class_score, score);
    endtask

    task automatic take_result();
        bus.result_ready = 1'b1;
        @(posedge clk); #2;
        bus.result_ready = 1'b0;
        check("c_ready_after_take", {31'd0, bus.c_ready}, 32'd1);
    endtask

    logic [31:0] asc [10];
    logic [31:0] mix [10];
    logic [31:0] tie [10];
    logic [31:0] nan [10];

    initial begin
        asc = '{32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000, 32'h4110_0000};
        for (int k = 0; k < 10; k++) mix[k] = 32'hC000_0000;
        mix[3] = 32'h3F00_0000;
        mix[7] = 32'h8000_0000;
        for (int k = 0; k < 10; k++) nan[k] = 32'hFF80_0000;
        nan[4] = 32'h7F80_0000;
        nan[6] = 32'h7FC0_0000;
        nan[8] = 32'hFFC0_0000;

        rst_n            = 1'b0;
        flush            = 1'b0;
        bus.c_valid      = 1'b0;
        bus.c_in         = '0;
        bus.result_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        check("rst_c_ready", {31'd0, bus.c_ready}, 32'd1);
        check("rst_result_valid", {31'd0, bus.result_valid}, 32'd0);
        check("rst_class_idx", {28'd0, bus.class_idx}, 32'd0);
        check("rst_class_score", bus.class_score, 32'd0);
        check("rst_frame_cnt", {28'd0, bus.frame_cnt}, 32'd0);

        // Ascending, then backpressure with c_valid pushing extra beats.
        send_frame(asc, 1'b0);
        expect_result("asc", 9, 32'h4110_0000);
        bus.c_valid = 1'b1;
        bus.c_in    = 32'h7F7F_FFFF;
        repeat (20) @(posedge clk);
        #2;
        check("bp_c_ready", {31'd0, bus.c_ready}, 32'd0);
        check("bp_frame_cnt", {28'd0, bus.frame_cnt}, 32'd10);
        expect_result("bp", 9, 32'h4110_0000);
        bus.c_valid = 1'b0;
        take_result();

        send_frame(mix, 1'b0);
        expect_result("mix", 3, 32'h3F00_0000);
        take_result();

        for (int k = 0; k < 10; k++) tie[k] = 32'h8000_0000;
        tie[2] = 32'h0000_0000;
        tie[5] = 32'h0000_0000;
        send_frame(tie, 1'b0);
        expect_result("tie", 2, 32'h0000_0000);
        take_result();

        tie[2] = 32'h8000_0000;
        send_frame(tie, 1'b1);
        expect_result("zero_sign", 5, 32'h0000_0000);
        take_result();

        send_frame(nan, 1'b1);
        expect_result("nan", 6, 32'h7FC0_0000);
        take_result();

        // Flush after 6 beats, coinciding with a 7th beat.
        for (int k = 0; k < 6; k++) begin
            bus.c_valid = 1'b1;
            bus.c_in    = 32'h7F00_0000;
            @(posedge clk); #2;
        end
        flush = 1'b1;
        @(posedge clk); #2;
        flush       = 1'b0;
        bus.c_valid = 1'b0;
        check("flush_frame_cnt", {28'd0, bus.frame_cnt}, 32'd0);
        check("flush_result_valid", {31'd0, bus.result_valid}, 32'd0);
        send_frame(asc, 1'b0);
        expect_result("post_flush", 9, 32'h4110_0000);
        take_result();

        // Asynchronous reset mid-frame.
        for (int k = 0; k < 3; k++) begin
            bus.c_valid = 1'b1;
            bus.c_in    = 32'h7F00_0000;
            @(posedge clk); #2;
        end
        bus.c_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_frame_cnt", {28'd0, bus.frame_cnt}, 32'd0);
        check("arst_class_score", bus.class_score, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        send_frame(mix, 1'b0);
        expect_result("post_rst", 3, 32'h3F00_0000);
        take_result();

        repeat (2) @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mnist_dlayer2_result_collector.md
# mnist_dlayer2_result_collector

Consumer for the output layer's dot-product node results. Accepts one 32-bit IEEE-754 single-precision score per handshake beat, one beat per output class in class order 0..NUM_CLASSES-1. After the last class it presents the winning class index (argmax) and its score on a valid/ready result port. It sits directly downstream of the layer-2 node unit's `c` output and terminates the inference datapath.

## Interface
- `NUM_CLASSES`, 10, number of scores per frame (class count)
- `DATA_W`, 32, score width (fp32 bit pattern)
- `IDX_W`, 4, class index width; must satisfy 2^IDX_W >= NUM_CLASSES
- `clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `flush`  in  1  synchronous frame abort
- `c_in`  in  DATA_W  node result score
- `c_valid`  in  1  `c_in` holds the score for the next class
- `c_ready`  out  1  collector can accept a score
- `result_valid`  out  1  argmax result available
- `result_ready`  in  1  downstream accepts result
- `class_idx`  out  IDX_W  winning class index
- `class_score`  out  DATA_W  winning score bit pattern
- `frame_cnt`  out  IDX_W  number of scores accepted in current frame

## Operation
- FSM states:
  - COLLECT (reset state)
  - DONE
- COLLECT:
  - `c_ready`=1.
  - Each beat with `c_valid && c_ready` is accepted: score stored, running max updated, `frame_cnt` incremented.
  - The beat with `frame_cnt == NUM_CLASSES-1` moves the FSM to DONE.
- DONE:
  - `c_ready`=0, `result_valid`=1.
  - `class_idx` and `class_score` are held stable.
  - `result_valid && result_ready` returns the FSM to COLLECT and clears `frame_cnt`, `class_idx` and `class_score` to 0.
- Compare rule:
  - Order key: key(x) = x[31] ? ~x : x | 32'h8000_0000. Unsigned compare on the key.
  - Resulting order: +0 > -0; positive NaN > +inf; negative NaN < -inf.
- Update rule:
  - The first beat of a frame always loads the max.
  - Later beats replace the max only if key(new) > key(max), strictly greater.
  - Ties resolve to the lowest class index.
- `flush`:
  - Highest priority, any state.
  - Next cycle: COLLECT, `frame_cnt`=0, `result_valid`=0, max cleared.
  - A beat presented in the same cycle as `flush` is discarded.
- `c_valid` while `c_ready`=0: ignored. Upstream holds the beat until `c_ready` is seen high.

## Timing
- Reset values:
  - `c_ready`=1
  - `result_valid`=0
  - `class_idx`=0
  - `class_score`=0
  - `frame_cnt`=0
- Handshake: one score per cycle at full rate. All outputs are registered except `c_ready`, which is decoded from state.
- Result latency: `result_valid` rises on the cycle after the NUM_CLASSES-th accepted beat.
- Recovery: `c_ready` rises on the cycle after the result handshake. The minimum frame period is NUM_CLASSES+1 cycles.
- A result is held indefinitely while `result_ready`=0. It is never dropped except by `flush` or reset.
- Reset mid-frame: immediate return to reset values; the partial frame is lost.

## Configuration
- Macro: `MNIST_SCORE_READBACK_EN`.
- Defined:
  - Adds a NUM_CLASSES x DATA_W score buffer, written on each accepted beat at index `frame_cnt`.
  - Adds ports `rd_idx` (in, IDX_W) and `rd_data` (out, DATA_W).
  - `rd_data` is combinational from the buffer; it returns 0 for `rd_idx` >= NUM_CLASSES.
  - Buffer contents persist until overwritten; they are not cleared by `flush`.
  - Buffer resets to 0.
- Undefined: no buffer and no readback ports; only the running max is kept.

## Structure
- Shared package `mnist_pkg`:
  - constants NUM_CLASSES, DATA_W, IDX_W
  - collector state enum (COLLECT, DONE)
  - function `fp32_order_key`
- One combinational sub-module `mnist_fp32_cmp_gt` (inputs a, b; output gt = key(a) > key(b)), instantiated once in the max-update path.

## Test plan
- Ascending scores: class k = k*1.0 (0x0, 0x3F800000 … 0x41100000), back-to-back beats -> `result_valid` one cycle after the 10th beat, `class_idx`=9, `class_score`=0x41100000.
- Mixed signs: all classes -2.0 (0xC0000000) except class 3 = 0.5 (0x3F000000) and class 7 = -0.0 (0x80000000) -> `class_idx`=3, `class_score`=0x3F000000.
- Tie and zeros: class 2 = +0 and class 5 = +0, all others -0 -> `class_idx`=2. With class 2 = -0 and class 5 = +0, all others -0 -> `class_idx`=5.
- Backpressure: hold `result_ready`=0 for 20 cycles while asserting `c_valid` -> `c_ready`=0, result stable, no beat accepted. Release `result_ready` -> `c_ready`=1 the next cycle.
- Flush: assert `flush` after 6 beats, alongside a 7th `c_valid` -> `frame_cnt`=0, `result_valid`=0. A fresh 10-beat frame then gives a correct argmax unaffected by the aborted frame.
- Readback (macro defined): after a frame with class k = 0x3F800000+k, `rd_idx`=4 -> `rd_data`=0x3F800004; `rd_idx`=12 -> 0.
